// File: rtl/mult_ctrl_pkg.sv
// rtl/mult_ctrl_pkg.sv - shared sizes for the multiplier arbitration controller
package mult_ctrl_pkg;
  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;
  localparam int OPND_W = 8;
  localparam int PROD_W = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, search starts at ptr and wraps
module rr_arbiter #(
  parameter int N_REQ = mult_ctrl_pkg::N_REQ,
  parameter int ID_W  = mult_ctrl_pkg::ID_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/mult_arb_ctrl.sv
// rtl/mult_arb_ctrl.sv - shares one registered 8x8 multiplier among N_REQ requesters
module mult_arb_ctrl
  import mult_ctrl_pkg::OPND_W;
  import mult_ctrl_pkg::PROD_W;
#(
  parameter int N_REQ = mult_ctrl_pkg::N_REQ,
  parameter int ID_W  = mult_ctrl_pkg::ID_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N_REQ-1:0]          req,
  input  logic [OPND_W*N_REQ-1:0]   a_in,
  input  logic [OPND_W*N_REQ-1:0]   b_in,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [PROD_W-1:0]         rsp_data,
  output logic                      mul_start,
  output logic [OPND_W-1:0]         mul_a,
  output logic [OPND_W-1:0]         mul_b,
  input  logic [PROD_W-1:0]         mul_p
);

  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_any;
  logic             t1_valid, t2_valid;
  logic [ID_W-1:0]  t1_id, t2_id;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // t1 tracks the op at the multiplier input, t2 the op whose product is on mul_p
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr       <= '0;
      gnt       <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      t1_valid  <= 1'b0;
      t1_id     <= '0;
      t2_valid  <= 1'b0;
      t2_id     <= '0;
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      gnt       <= '0;
      mul_start <= 1'b0;
      t1_valid  <= 1'b0;
      if (en && arb_any) begin
        gnt       <= arb_gnt;
        mul_start <= 1'b1;
        mul_a     <= a_in[int'(arb_idx)*OPND_W +: OPND_W];
        mul_b     <= b_in[int'(arb_idx)*OPND_W +: OPND_W];
        t1_valid  <= 1'b1;
        t1_id     <= arb_idx;
        ptr       <= (arb_idx == ID_W'(N_REQ-1)) ? '0 : arb_idx + 1'b1;
      end
      t2_valid  <= t1_valid;
      t2_id     <= t1_id;
      rsp_valid <= {{(N_REQ-1){1'b0}}, t2_valid} << t2_id;
      if (t2_valid) begin
        rsp_id   <= t2_id;
        rsp_data <= mul_p;
      end
    end
  end

endmodule

// File: tb/tb_mult_arb_ctrl.sv
// tb/tb_mult_arb_ctrl.sv - scoreboard bench for mult_arb_ctrl with a registered multiplier
module tb_mult_arb_ctrl;
  localparam int N = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst, en;
  logic [N-1:0]   req;
  logic [8*N-1:0] a_in, b_in;
  logic [N-1:0]   gnt, rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [15:0]    rsp_data, mul_p;
  logic           mul_start;
  logic [7:0]     mul_a, mul_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_arb_ctrl #(.N_REQ(N), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  // the external registered multiplier
  always @(posedge clk) begin
    if (!rst) mul_p <= '0;
    else      mul_p <= mul_start ? 16'(mul_a) * 16'(mul_b) : 16'd0;
  end

  typedef struct { int id; int data; int due; } exp_t;
  exp_t       q[$];
  int         cyc = 0;
  int         m_start = 0;
  bit         started = 0;
  logic [N-1:0] exp_gnt;
  logic [7:0] exp_a, exp_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // reference model: pick first active index from m_start onward, wrapping
  always @(posedge clk) begin
    int pick, j, prod;
    exp_t e;
    cyc++;
    started = 1;
    if (!rst) begin
      q.delete();
      m_start = 0;
      exp_gnt = '0;
      exp_a   = '0;
      exp_b   = '0;
    end else begin
      pick = -1;
      if (en) begin
        for (int k = 0; k < N; k++) begin
          j = (m_start + k) % N;
          if (pick < 0 && req[j]) pick = j;
        end
      end
      if (pick >= 0) begin
        exp_gnt = '0;
        exp_gnt[pick] = 1'b1;
        exp_a   = a_in[8*pick +: 8];
        exp_b   = b_in[8*pick +: 8];
        prod    = int'(exp_a) * int'(exp_b);
        e.id = pick; e.data = prod; e.due = cyc + 2;
        q.push_back(e);
        m_start = (pick + 1) % N;
      end else begin
        exp_gnt = '0;
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    exp_t e;
    logic [N-1:0] oh;
    if (started) begin
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("mul_start", 32'(mul_start), 32'(exp_gnt != '0));
      chk("mul_a", 32'(mul_a), 32'(exp_a));
      chk("mul_b", 32'(mul_b), 32'(exp_b));
      if (rsp_valid !== '0) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = q.pop_front();
          oh = '0;
          oh[e.id] = 1'b1;
          chk("rsp_valid", 32'(rsp_valid), 32'(oh));
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_latency", 32'(cyc), 32'(e.due));
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("rsp_missing", 32'(rsp_valid), 32'(1 << e.id));
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic [N-1:0] rq,
                       input logic [8*N-1:0] a, input logic [8*N-1:0] b);
    @(posedge clk);
    #1;
    rst = r; en = e; req = rq; a_in = a; b_in = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, '0, a_in, b_in);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; req = '0; a_in = '0; b_in = '0;
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b0, 1'b1, 4'b1111, 32'h01020304, 32'h05060708);
    @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_mul", {mul_a, mul_b, 15'd0, mul_start}, 32'd0);

    drive(1'b1, 1'b1, '0, '0, '0);
    // single request: 12 * 11
    drive(1'b1, 1'b1, 4'b0001, 32'h0000000c, 32'h0000000b);
    idle(5);

    // all four continuously
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b1, 4'b1111, 32'h04030201, 32'h50463c32);
    idle(4);

    // boundary operands
    drive(1'b1, 1'b1, 4'b0001, 32'h000000ff, 32'h000000ff);
    drive(1'b1, 1'b1, 4'b0010, 32'h00000000, 32'h0000c800);
    idle(4);

    // en drops after one grant, then resumes
    drive(1'b1, 1'b1, 4'b1111, 32'h09080706, 32'h0d0c0b0a);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'b1111, 32'h09080706, 32'h0d0c0b0a);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 4'b1111, 32'h09080706, 32'h0d0c0b0a);
    idle(4);

    // reset one cycle after a grant
    drive(1'b1, 1'b1, 4'b0110, 32'h00112233, 32'h44556677);
    drive(1'b0, 1'b1, 4'b0110, 32'h00112233, 32'h44556677);
    drive(1'b1, 1'b1, 4'b1100, 32'h11223344, 32'h55667788);
    drive(1'b1, 1'b1, 4'b0000, 32'h11223344, 32'h55667788);
    idle(4);

    // randomized traffic with occasional reset and en gaps
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 60) != 0, ($urandom % 5) != 0, N'($urandom),
            {$urandom}, {(($urandom % 4) == 0) ? 8'd0 : 8'($urandom), 24'($urandom)});
    end
    idle(6);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_arb_ctrl.md
MULT_ARB_CTRL -- requirements
Module: mult_arb_ctrl

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing one 8x8 multiplier.
REQ-002 Parameter: ID_W, default 2, requester index width, equal to clog2(N_REQ).
REQ-003 Clock and reset: one clock; reset is synchronous and active-low (ports clk, rst).
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 en  input  1  high = new grants allowed; low = no new grants, in-flight ops still complete.
REQ-007 req  input  N_REQ  per-requester request level.
REQ-008 a_in  input  8*N_REQ  packed operand A, slice i belongs to requester i.
REQ-009 b_in  input  8*N_REQ  packed operand B, slice i belongs to requester i.
REQ-010 gnt  output  N_REQ  one-hot, one-cycle accept pulse.
REQ-011 rsp_valid  output  N_REQ  one-hot, one-cycle result pulse.
REQ-012 rsp_id  output  ID_W  index of the requester owning rsp_data.
REQ-013 rsp_data  output  16  unsigned product.
REQ-014 mul_start  output  1  start strobe to the shared multiplier.
REQ-015 mul_a / mul_b  output  8 each  operands to the shared multiplier.
REQ-016 mul_p  input  16  multiplier product, registered one cycle after mul_start; zero when not started.

Function
REQ-017 Arbitration: round-robin; search starts at last-granted index + 1 and wraps from N_REQ-1 to 0.
REQ-018 At edge E with en=1 and req!=0: grant the selected i, so gnt[i]=1, mul_start=1, mul_a=a_in[i], mul_b=b_in[i] and tag id=i become valid in cycle E+1.
REQ-019 Throughput: one grant per cycle maximum; back-to-back grants allowed with no bubble.
REQ-020 Result: mul_p is captured at edge E+2; rsp_valid[i]=1, rsp_id=i and rsp_data=mul_p are asserted in cycle E+2 to E+3, exactly one cycle.
REQ-021 Fixed latency: 2 cycles from gnt pulse to rsp_valid pulse; there is no backpressure on the response.
REQ-022 Requester rule: hold req and operands stable until gnt is seen; req may stay high after gnt to request again.
REQ-023 The round-robin pointer updates only on a grant and holds otherwise.
REQ-024 With en=0 or req=0: gnt=0, mul_start=0, and mul_a/mul_b hold their previous values; in-flight results still emerge.
REQ-025 When en falls mid-stream: a grant already issued completes normally; no new grant is issued from the next edge onward.
REQ-026 If a single requester is active continuously, it is granted every cycle.
REQ-027 rsp_valid is driven only from the internal valid tag and never inferred from mul_p being nonzero, so a product of 0 is reported.
REQ-028 Pipeline: 2-stage tag shift register (valid, id); N_REQ*... no other state.

Reset
REQ-029 With rst=0 at an edge, the following all become 0: gnt, rsp_valid, rsp_id, rsp_data, mul_start, mul_a, mul_b, the tag pipeline, and the pointer (first search starts at index 0).
REQ-030 Reset mid-operation discards all in-flight operations; no rsp_valid is produced for them after release.
REQ-031 A grant may be issued at the first edge after rst returns high.

Structure
REQ-032 Shared package mult_ctrl_pkg holds N_REQ, ID_W, OPND_W=8 and PROD_W=16.
REQ-033 Sub-module rr_arbiter (req, pointer -> one-hot grant + index) is combinational and is instantiated once.
REQ-034 The multiplier stays external; the bench instantiates the existing 8x8 registered multiplier on the same clk/rst.

Verification
REQ-035 Single request: req=0001, a=12, b=11 -> gnt[0] pulse, then 2 cycles later rsp_valid=0001, rsp_id=0, rsp_data=132.
REQ-036 All four requesting continuously with distinct operands -> gnt sequence 0001, 0010, 0100, 1000, 0001..., one per cycle, and the matching products appear in the same order 2 cycles later.
REQ-037 Boundary operands: a=255, b=255 -> rsp_data=65025; a=0, b=200 -> rsp_valid is asserted with rsp_data=0.
REQ-038 en drops 1 cycle after grants start -> exactly 1 further result emerges, then no gnt while en=0; resumes from the next pointer.
REQ-039 rst asserted 1 cycle after a grant -> no rsp_valid after release; the first grant after release goes to the lowest active index.
